regfile_write_arbiter: RTL

- Shares the register file's single write port between processor writeback (CPU) and game-I/O writers (button and timer status).
- I/O writes are buffered in a small FIFO and drained when the CPU does not write.
- A starvation counter forces a one-cycle CPU stall so that I/O writes cannot wait forever.
- Writes to hardware-owned registers are dropped and flagged.

---
 rtl/regfile_write_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file write port between CPU writeback and a small FIFO of I/O writes,
// with a starvation-forced CPU stall and dropping of writes to hardware-owned registers.
module regfile_write_arbiter #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_WAIT   = 8,
  parameter logic [31:0] PROT_MASK  = 32'h2000_0001
) (
  input  logic                          clock,
  input  logic                          ctrl_reset,
  input  logic                          cpu_we,
  input  logic [4:0]                    cpu_reg,
  input  logic [31:0]                   cpu_data,
  output logic                          cpu_stall,
  input  logic                          io_valid,
  output logic                          io_ready,
  input  logic [4:0]                    io_reg,
  input  logic [31:0]                   io_data,
  output logic                          rf_we,
  output logic [4:0]                    rf_reg,
  output logic [31:0]                   rf_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          prot_violation
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(MAX_WAIT) + 1;

  typedef enum logic {NORMAL, FORCE} arbStateT;

  arbStateT       state;
  logic [4:0]     fifoReg  [FIFO_DEPTH];
  logic [31:0]    fifoData [FIFO_DEPTH];
  logic [AW-1:0]  wrPtr;
  logic [AW-1:0]  rdPtr;
  logic [AW:0]    count;
  logic [AW:0]    countNext;
  logic [WW-1:0]  waitCnt;

  logic           push;
  logic           nonEmpty;
  logic           forceNow;
  logic           grantFifo;
  logic           grantCpu;
  logic           grant;
  logic           headStarved;
  logic           goForce;
  logic           isProt;
  logic [4:0]     grantReg;
  logic [31:0]    grantData;

  // In FORCE the CPU request is ignored so the FIFO head always wins that cycle.
  always_comb begin
    push        = io_valid & io_ready;
    nonEmpty    = (count != '0);
    forceNow    = (state == FORCE);
    grantFifo   = nonEmpty & (forceNow | ~cpu_we);
    grantCpu    = ~forceNow & cpu_we;
    grant       = grantFifo | grantCpu;
    grantReg    = grantFifo ? fifoReg[rdPtr]  : cpu_reg;
    grantData   = grantFifo ? fifoData[rdPtr] : cpu_data;
    isProt      = PROT_MASK[grantReg];
    countNext   = count + (AW+1)'(push) - (AW+1)'(grantFifo);
    headStarved = nonEmpty & ~grantFifo;
    goForce     = headStarved & (waitCnt == WW'(MAX_WAIT - 1));
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state          <= NORMAL;
      cpu_stall      <= 1'b0;
      waitCnt        <= '0;
      count          <= '0;
      wrPtr          <= '0;
      rdPtr          <= '0;
      io_ready       <= 1'b0;
      rf_we          <= 1'b0;
      rf_reg         <= '0;
      rf_data        <= '0;
      prot_violation <= 1'b0;
    end else begin
      state          <= goForce ? FORCE : NORMAL;
      cpu_stall      <= goForce;
      waitCnt        <= (headStarved & ~goForce) ? waitCnt + WW'(1) : '0;
      count          <= countNext;
      wrPtr          <= wrPtr + AW'(push);
      rdPtr          <= rdPtr + AW'(grantFifo);
      io_ready       <= (countNext < (AW+1)'(FIFO_DEPTH));
      rf_we          <= grant & ~isProt;
      prot_violation <= grant & isProt;
      if (grant & ~isProt) begin
        rf_reg  <= grantReg;
        rf_data <= grantData;
      end
    end
  end

  // Queue storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clock) begin
    if (push) begin
      fifoReg[wrPtr]  <= io_reg;
      fifoData[wrPtr] <= io_data;
    end
  end

  assign fifo_count = count;

endmodule
